fare_gate_ctrl: RTL and testbench
=================================

// Module: fare_gate_ctrl
// PURPOSE
//  Parametrised successor of the single-fare turnstile FSM. Debounces card presence,
//  latches balance, checks it against FARE, shows the remainder, writes the new balance
//  back over a valid/ready handshake, then opens the gate. It also keeps saturating
//  pass/deny statistics. Sits between the card-reader front end and the gate/display drivers.
// PARAMETERS
//  BAL_W      8  balance / display-value width, bits
//  FARE       4  fare deducted per entry (< 2**BAL_W)
//  WAIT_CYC   3  idle dwell cycles before run is sampled (>=1)
//  READ_CYC   3  cycles run must stay high to accept a card (>=1)
//  SHOW_CYC   4  cycles remainder/deny is displayed (>=1)
//  OPEN_CYC   5  cycles gate_open is asserted (>=1)
//  WB_TIMEOUT 8  max cycles waiting for wb_ready before abort (>=1)
//  STAT_W    16  width of pass_cnt / deny_cnt
// PORTS
//  clk         in   1      system clock, all logic on posedge
//  reset       in   1      synchronous, active-high reset
//  run         in   1      card present at reader
//  balance     in   BAL_W  card balance, sampled on last READ cycle
//  wb_ready    in   1      card writer accepts wb_balance
//  wb_valid    out  1      write-back request
//  wb_balance  out  BAL_W  new balance (latched balance - FARE)
//  disp_code   out  3      0 OFF,1 WAIT,2 READ,3 BAL,4 DENY,5 GO,6 ERR
//  disp_val    out  BAL_W  value shown alongside disp_code (0 unless BAL/DENY)
//  gate_open   out  1      gate release
//  pass_cnt    out  STAT_W completed entries, saturating
//  deny_cnt    out  STAT_W denials + write-back aborts, saturating
// BEHAVIOUR
//  - Reset: on a clk edge with reset=1: state<=RES, cnt<=0, bal_q<=0, stats<=0.
//    Effect: wb_valid=0, gate_open=0, disp_code=0, disp_val=0, wb_balance=0.
//    Reset is honoured in every state, including mid-handshake and while the gate is open.
//  - Outputs are Moore decodes of the registered state, cnt and bal_q; no input-to-output paths.
//  - cnt clears on every state change. A dwell of N cycles ends when cnt==N-1.
//    Width is $clog2(max cycle param + 1).
//  - RES: 1 cycle -> WAIT.
//  - WAIT (code 1): after WAIT_CYC cycles: run=1 -> READ, else restart the WAIT dwell.
//  - READ (code 2):
//    - run=0 on any READ cycle -> WAIT next edge. This abort has priority over completion.
//    - Last cycle with run=1: bal_q<=balance. Then:
//      - balance>=FARE -> BAL.
//      - Otherwise -> DENY, and deny_cnt increments.
//  - BAL (code 3, disp_val=bal_q-FARE): SHOW_CYC cycles -> WB.
//  - WB (code 3): wb_valid=1, wb_balance=bal_q-FARE, held stable while wb_valid=1.
//    - Transfer on the edge where wb_valid&wb_ready -> OPEN. A transfer on the first WB cycle is legal.
//    - No transfer within WB_TIMEOUT cycles -> ERR, and deny_cnt increments.
//      If ready arrives on the timeout cycle, the transfer wins.
//  - OPEN (code 5, gate_open=1): OPEN_CYC cycles -> WAIT. pass_cnt increments on entry to OPEN.
//  - DENY (code 4, disp_val=bal_q): SHOW_CYC cycles -> WAIT.
//  - ERR (code 6): SHOW_CYC cycles -> WAIT. gate never opens.
//  - run is ignored outside WAIT/READ. A card held through OPEN re-reads only after a full WAIT.
//  - Arithmetic is unsigned BAL_W. The compare is >=, so balance==FARE is accepted and shows 0.
//  - Stats saturate at 2**STAT_W-1 and never wrap.
//  - Illegal state encodings -> RES next edge.
// TESTING (defaults)
//  1) Release reset, hold run=1, balance=9, wb_ready=1.
//     -> RES 1 cycle, WAIT 3, READ 3, BAL 4 with disp_val=5.
//     -> WB 1 cycle with wb_balance=5, OPEN 5 cycles, pass_cnt=1.
//  2) balance=3 -> after READ, DENY 4 cycles with disp_val=3, deny_cnt=1, gate_open stays 0.
//     balance=4 -> accepted, disp_val=0, wb_balance=0.
//  3) run drops on the 2nd READ cycle -> WAIT next edge, bal_q unchanged, no stats change.
//  4) wb_ready=0 throughout WB -> wb_valid high 8 cycles with stable wb_balance, then ERR 4 cycles, deny_cnt+1.
//     Repeat with wb_ready pulsed on the 8th WB cycle -> OPEN.
//  5) Assert reset for 1 cycle during OPEN and during WB -> next cycle gate_open=0, wb_valid=0, disp_code=0, stats=0.
//  6) STAT_W=2: four passes -> pass_cnt sticks at 3.

Source files
------------

// File: rtl/fare_gate_ctrl.sv
// Fare gate controller: debounced card read, fare check, balance write-back,
// gate release and saturating pass/deny statistics.
module fare_gate_ctrl #(
  parameter int BAL_W      = 8,
  parameter int FARE       = 4,
  parameter int WAIT_CYC   = 3,
  parameter int READ_CYC   = 3,
  parameter int SHOW_CYC   = 4,
  parameter int OPEN_CYC   = 5,
  parameter int WB_TIMEOUT = 8,
  parameter int STAT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [BAL_W-1:0]  balance,
  input  logic              wb_ready,
  output logic              wb_valid,
  output logic [BAL_W-1:0]  wb_balance,
  output logic [2:0]        disp_code,
  output logic [BAL_W-1:0]  disp_val,
  output logic              gate_open,
  output logic [STAT_W-1:0] pass_cnt,
  output logic [STAT_W-1:0] deny_cnt
);

  function automatic int maxi(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXC = maxi(maxi(maxi(WAIT_CYC, READ_CYC),
                                  maxi(SHOW_CYC, OPEN_CYC)),
                             WB_TIMEOUT);
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [BAL_W-1:0] FARE_V = BAL_W'(FARE);

  localparam logic [CW-1:0] WAIT_END = CW'(WAIT_CYC - 1);
  localparam logic [CW-1:0] READ_END = CW'(READ_CYC - 1);
  localparam logic [CW-1:0] SHOW_END = CW'(SHOW_CYC - 1);
  localparam logic [CW-1:0] OPEN_END = CW'(OPEN_CYC - 1);
  localparam logic [CW-1:0] WB_END   = CW'(WB_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_RES,
    S_WAIT,
    S_READ,
    S_BAL,
    S_WB,
    S_OPEN,
    S_DENY,
    S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BAL_W-1:0]  bal_q, bal_d;
  logic [STAT_W-1:0] pass_q, pass_d;
  logic [STAT_W-1:0] deny_q, deny_d;
  logic              pass_inc, deny_inc;
  logic              restart;
  logic [BAL_W-1:0]  remain;

  assign remain = bal_q - FARE_V;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RES;
      cnt_q   <= '0;
      bal_q   <= '0;
      pass_q  <= '0;
      deny_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bal_q   <= bal_d;
      pass_q  <= pass_d;
      deny_q  <= deny_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bal_d    = bal_q;
    pass_inc = 1'b0;
    deny_inc = 1'b0;
    restart  = 1'b0;
    unique case (state_q)
      S_RES: state_d = S_WAIT;
      S_WAIT: begin
        if (cnt_q == WAIT_END) begin
          if (run) state_d = S_READ;
          else     restart = 1'b1;
        end
      end
      S_READ: begin
        if (!run) begin
          state_d = S_WAIT;
        end else if (cnt_q == READ_END) begin
          bal_d = balance;
          if (balance >= FARE_V) begin
            state_d = S_BAL;
          end else begin
            state_d  = S_DENY;
            deny_inc = 1'b1;
          end
        end
      end
      S_BAL: if (cnt_q == SHOW_END) state_d = S_WB;
      S_WB: begin
        // a late ready on the timeout cycle still completes the entry
        if (wb_ready) begin
          state_d  = S_OPEN;
          pass_inc = 1'b1;
        end else if (cnt_q == WB_END) begin
          state_d  = S_ERR;
          deny_inc = 1'b1;
        end
      end
      S_OPEN: if (cnt_q == OPEN_END) state_d = S_WAIT;
      S_DENY: if (cnt_q == SHOW_END) state_d = S_WAIT;
      S_ERR:  if (cnt_q == SHOW_END) state_d = S_WAIT;
      default: state_d = S_RES;
    endcase

    if (restart || state_d != state_q) cnt_d = '0;
    else                               cnt_d = cnt_q + CW'(1);

    pass_d = (pass_inc && pass_q != '1) ? pass_q + STAT_W'(1) : pass_q;
    deny_d = (deny_inc && deny_q != '1) ? deny_q + STAT_W'(1) : deny_q;
  end

  always_comb begin
    wb_valid   = 1'b0;
    wb_balance = '0;
    disp_code  = 3'd0;
    disp_val   = '0;
    gate_open  = 1'b0;
    unique case (state_q)
      S_RES:  disp_code = 3'd0;
      S_WAIT: disp_code = 3'd1;
      S_READ: disp_code = 3'd2;
      S_BAL: begin
        disp_code = 3'd3;
        disp_val  = remain;
      end
      S_WB: begin
        disp_code  = 3'd3;
        wb_valid   = 1'b1;
        wb_balance = remain;
      end
      S_OPEN: begin
        disp_code = 3'd5;
        gate_open = 1'b1;
      end
      S_DENY: begin
        disp_code = 3'd4;
        disp_val  = bal_q;
      end
      S_ERR:  disp_code = 3'd6;
      default: disp_code = 3'd0;
    endcase
  end

  assign pass_cnt = pass_q;
  assign deny_cnt = deny_q;

endmodule

// File: tb/tb_fare_gate_ctrl.sv
// Bench for fare_gate_ctrl: phase-level reference model checked every cycle
// on a default instance and a STAT_W=2 instance sharing the same stimulus.
module tb_fare_gate_ctrl;

  localparam int WAIT_CYC = 3;
  localparam int READ_CYC = 3;
  localparam int SHOW_CYC = 4;
  localparam int OPEN_CYC = 5;
  localparam int WB_TO    = 8;
  localparam int FARE     = 4;

  localparam int P_RES  = 0;
  localparam int P_WAIT = 1;
  localparam int P_READ = 2;
  localparam int P_BAL  = 3;
  localparam int P_WB   = 4;
  localparam int P_OPEN = 5;
  localparam int P_DENY = 6;
  localparam int P_ERR  = 7;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [7:0] balance;
  logic       wb_ready;

  logic        wbv_a, gate_a;
  logic [7:0]  wbb_a, val_a;
  logic [2:0]  code_a;
  logic [15:0] pass_a, deny_a;

  logic        wbv_b, gate_b;
  logic [7:0]  wbb_b, val_b;
  logic [2:0]  code_b;
  logic [1:0]  pass_b, deny_b;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  int m_ph[2], m_t[2], m_bal[2], m_pass[2], m_deny[2];

  fare_gate_ctrl u_a (
    .clk(clk), .reset(reset), .run(run), .balance(balance),
    .wb_ready(wb_ready), .wb_valid(wbv_a), .wb_balance(wbb_a),
    .disp_code(code_a), .disp_val(val_a), .gate_open(gate_a),
    .pass_cnt(pass_a), .deny_cnt(deny_a)
  );

  fare_gate_ctrl #(.STAT_W(2)) u_b (
    .clk(clk), .reset(reset), .run(run), .balance(balance),
    .wb_ready(wb_ready), .wb_valid(wbv_b), .wb_balance(wbb_b),
    .disp_code(code_b), .disp_val(val_b), .gate_open(gate_b),
    .pass_cnt(pass_b), .deny_cnt(deny_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  function automatic int smax(input int id);
    return (id == 0) ? 65535 : 3;
  endfunction

  function automatic void enter(input int id, input int ph);
    m_ph[id] = ph;
    m_t[id]  = 0;
  endfunction

  // m_t counts cycles already spent in the current phase
  task automatic mstep(input int id);
    if (reset) begin
      enter(id, P_RES);
      m_bal[id]  = 0;
      m_pass[id] = 0;
      m_deny[id] = 0;
      return;
    end
    m_t[id]++;
    case (m_ph[id])
      P_RES: enter(id, P_WAIT);
      P_WAIT:
        if (m_t[id] >= WAIT_CYC) begin
          if (run) enter(id, P_READ);
          else     m_t[id] = 0;
        end
      P_READ:
        if (!run) enter(id, P_WAIT);
        else if (m_t[id] >= READ_CYC) begin
          m_bal[id] = int'(balance);
          if (int'(balance) >= FARE) enter(id, P_BAL);
          else begin
            enter(id, P_DENY);
            if (m_deny[id] < smax(id)) m_deny[id]++;
          end
        end
      P_BAL: if (m_t[id] >= SHOW_CYC) enter(id, P_WB);
      P_WB:
        if (wb_ready) begin
          enter(id, P_OPEN);
          if (m_pass[id] < smax(id)) m_pass[id]++;
        end else if (m_t[id] >= WB_TO) begin
          enter(id, P_ERR);
          if (m_deny[id] < smax(id)) m_deny[id]++;
        end
      P_OPEN: if (m_t[id] >= OPEN_CYC) enter(id, P_WAIT);
      default: if (m_t[id] >= SHOW_CYC) enter(id, P_WAIT);
    endcase
  endtask

  always @(posedge clk) begin
    mstep(0);
    mstep(1);
  end

  task automatic cmp_dut(input int id, input logic wbv, input logic [7:0] wbb,
                         input logic [2:0] code, input logic [7:0] val,
                         input logic gate, input int pc, input int dc);
    int ph, rem, ecode, eval;
    ph  = m_ph[id];
    rem = (m_bal[id] - FARE) & 255;
    case (ph)
      P_RES:  ecode = 0;
      P_WAIT: ecode = 1;
      P_READ: ecode = 2;
      P_BAL, P_WB: ecode = 3;
      P_OPEN: ecode = 5;
      P_DENY: ecode = 4;
      default: ecode = 6;
    endcase
    eval = (ph == P_BAL) ? rem : (ph == P_DENY) ? m_bal[id] : 0;
    chk($sformatf("dut%0d code", id), 32'(code), 32'(ecode));
    chk($sformatf("dut%0d disp_val", id), 32'(val), 32'(eval));
    chk($sformatf("dut%0d wb_valid", id), 32'(wbv), 32'(ph == P_WB));
    chk($sformatf("dut%0d wb_balance", id), 32'(wbb),
        32'((ph == P_WB) ? rem : 0));
    chk($sformatf("dut%0d gate", id), 32'(gate), 32'(ph == P_OPEN));
    chk($sformatf("dut%0d pass", id), 32'(pc), 32'(m_pass[id]));
    chk($sformatf("dut%0d deny", id), 32'(dc), 32'(m_deny[id]));
  endtask

  always @(negedge clk) begin
    if (armed) begin
      cmp_dut(0, wbv_a, wbb_a, code_a, val_a, gate_a,
              int'(pass_a), int'(deny_a));
      cmp_dut(1, wbv_b, wbb_b, code_b, val_b, gate_b,
              int'(pass_b), int'(deny_b));
    end
  end

  function automatic int sig_a(input int sel);
    return (sel == 0) ? int'(code_a) : int'(wbv_a);
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_for(input string nm, input int sel, input int v);
    int n = 0;
    while (sig_a(sel) != v && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sig_a(sel) != v) begin
      checks++;
      errors++;
      $display("FAIL timeout %s act=%0d exp=%0d", nm, sig_a(sel), v);
    end
  endtask

  task automatic run_len(input int c, output int n);
    n = 0;
    while (int'(code_a) == c && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  int trace[18] = '{0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 3, 3, 5, 5, 5, 5, 5, 1};

  initial begin
    int n;
    reset    = 1'b1;
    run      = 1'b1;
    balance  = 8'd9;
    wb_ready = 1'b1;
    cyc(2);
    reset = 1'b0;
    armed = 1'b1;

    // 1) full accepted entry
    for (int i = 0; i < 18; i++) begin
      chk($sformatf("t1 code[%0d]", i), 32'(code_a), 32'(trace[i]));
      if (i == 7)  chk("t1 bal val", 32'(val_a), 32'd5);
      if (i == 11) chk("t1 wb_bal", 32'(wbb_a), 32'd5);
      if (i == 11) chk("t1 wb_valid", 32'(wbv_a), 32'd1);
      if (i == 12) chk("t1 pass", 32'(pass_a), 32'd1);
      cyc(1);
    end

    // 2) denial, then exact-fare acceptance
    balance = 8'd3;
    wait_for("t2 deny", 0, 4);
    chk("t2 deny val", 32'(val_a), 32'd3);
    chk("t2 deny cnt", 32'(deny_a), 32'd1);
    chk("t2 gate", 32'(gate_a), 32'd0);
    run_len(4, n);
    chk("t2 deny len", 32'(n), 32'd4);
    balance = 8'd4;
    wait_for("t2 bal", 0, 3);
    chk("t2 bal val", 32'(val_a), 32'd0);
    wait_for("t2 wb", 1, 1);
    chk("t2 wb_bal", 32'(wbb_a), 32'd0);
    wait_for("t2 open", 0, 5);
    chk("t2 pass", 32'(pass_a), 32'd2);

    // 3) card pulled during READ
    wait_for("t3 wait", 0, 1);
    balance = 8'd20;
    wait_for("t3 read", 0, 2);
    cyc(1);
    run = 1'b0;
    cyc(1);
    chk("t3 abort", 32'(code_a), 32'd1);
    chk("t3 pass", 32'(pass_a), 32'd2);
    chk("t3 deny", 32'(deny_a), 32'd1);
    run = 1'b1;

    // 4) write-back timeout, then ready on the last WB cycle
    wb_ready = 1'b0;
    balance  = 8'd10;
    wait_for("t4 wb", 1, 1);
    run_len(3, n);
    chk("t4 wb len", 32'(n), 32'd8);
    run_len(6, n);
    chk("t4 err len", 32'(n), 32'd4);
    chk("t4 deny", 32'(deny_a), 32'd2);
    wait_for("t4 wb2", 1, 1);
    cyc(7);
    wb_ready = 1'b1;
    cyc(1);
    wb_ready = 1'b0;
    chk("t4 late ready", 32'(code_a), 32'd5);
    chk("t4 pass", 32'(pass_a), 32'd3);

    // 5) reset during OPEN and during WB
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("t5 gate", 32'(gate_a), 32'd0);
    chk("t5 code", 32'(code_a), 32'd0);
    chk("t5 pass", 32'(pass_a), 32'd0);
    chk("t5 deny", 32'(deny_a), 32'd0);
    wait_for("t5 wb", 1, 1);
    cyc(2);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("t5 wb_valid", 32'(wbv_a), 32'd0);
    chk("t5 code2", 32'(code_a), 32'd0);

    // 6) four passes: narrow counters saturate
    wb_ready = 1'b1;
    balance  = 8'd200;
    for (int k = 0; k < 4; k++) begin
      wait_for("t6 open", 0, 5);
      wait_for("t6 wait", 0, 1);
    end
    chk("t6 pass a", 32'(pass_a), 32'd4);
    chk("t6 pass b", 32'(pass_b), 32'd3);

    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
